// File: rtl/weight_fetch_ctrl.sv
// Read sequencer for the packed weight SRAM: streams a contiguous word range to the
// weight loader through a small credit-managed FIFO that hides the SRAM read latency.
module weight_fetch_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 100,
  parameter int LEN_WIDTH  = 15,
  parameter int MEM_WORDS  = 20001,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  sram_csb,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CHK_W = LEN_WIDTH + ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  sent_q, sent_d;
  logic                  csb_q, csb_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic             push, pop, credit_ok, range_bad;
  logic [1:0]       inflight;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_valid    = (count_q != '0);
  assign w_data     = fifo_mem[rd_ptr_q];
  assign w_last     = w_valid && (sent_q == len_q - LEN_WIDTH'(1));
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign sram_csb   = csb_q;
  assign sram_raddr = raddr_q;

  // Data returned this cycle belongs to the read issued last cycle.
  assign push      = rd_pend_q;
  assign pop       = w_valid && w_ready;
  assign inflight  = {1'b0, ~csb_q} + {1'b0, rd_pend_q};
  assign credit_ok = ((CNT_W + 1)'(count_q) + (CNT_W + 1)'(inflight)) < (CNT_W + 1)'(FIFO_DEPTH);
  assign range_bad = (CHK_W'(base_addr) + CHK_W'(num_words)) > CHK_W'(MEM_WORDS);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    issued_d  = issued_q;
    sent_d    = sent_q;
    csb_d     = 1'b1;
    raddr_d   = raddr_q;
    rd_pend_d = ~csb_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (pop) begin
      sent_d = sent_q + LEN_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else if (num_words == '0) begin
            done_d = 1'b1;
          end else begin
            // The FIFO is always empty in IDLE, so the first read can go out at once.
            base_d   = base_addr;
            len_d    = num_words;
            issued_d = LEN_WIDTH'(1);
            sent_d   = '0;
            csb_d    = 1'b0;
            raddr_d  = base_addr;
            busy_d   = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if ((issued_q < len_q) && credit_ok) begin
          csb_d    = 1'b0;
          raddr_d  = base_q + ADDR_WIDTH'(issued_q);
          issued_d = issued_q + LEN_WIDTH'(1);
        end
        if (issued_d == len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && w_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      sent_q    <= '0;
      csb_q     <= 1'b1;
      raddr_q   <= '0;
      rd_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      sent_q    <= sent_d;
      csb_q     <= csb_d;
      raddr_q   <= raddr_d;
      rd_pend_q <= rd_pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
        if (rst) begin
          fifo_mem[gi] <= '0;
        end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
          fifo_mem[gi] <= sram_rdata;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl: directed commands push expected words,
// a negedge monitor pops and compares on each handshake and gathers timing stats.
module tb_weight_fetch_ctrl;
  localparam int AW = 17;
  localparam int DW = 100;
  localparam int LW = 15;
  localparam int MW = 20001;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_words = '0;
  logic          busy, done, err, sram_csb, w_valid, w_last;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] w_data;
  logic          w_ready = 1'b1;

  weight_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                      .MEM_WORDS(MW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .err(err), .sram_csb(sram_csb), .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_last(w_last)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input int a);
    logic [31:0] x;
    x = (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    return {x[3:0], x, ~x, x ^ 32'hFFFF0000};
  endfunction

  // SRAM model with one-cycle registered read.
  always @(posedge clk) begin
    if (sram_csb == 1'b0) sram_rdata <= mem_word(int'(sram_raddr));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;
  int start_cyc = 0;
  int ready_mode = 0;
  logic [DW:0] exp_q[$];

  int csb_cnt, hs_cnt, done_cnt, err_cnt, busy_cnt, max_out, csb_at15, valid_cnt;
  int first_csb_rel, first_valid_rel, last_hs_rel, done_rel, err_rel;
  logic [AW-1:0] last_raddr;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  task automatic clear_stats();
    csb_cnt = 0; hs_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; max_out = 0;
    csb_at15 = -1; valid_cnt = 0;
    first_csb_rel = -1; first_valid_rel = -1; last_hs_rel = -1; done_rel = -1; err_rel = -1;
    last_raddr = '0;
  endtask

  // Issues a one-cycle start; expected words are queued only for accepted commands.
  task automatic begin_cmd(input int b, input int n, input bit accepted);
    @(posedge clk); #1;
    clear_stats();
    start_cyc = cyc;
    base_addr = AW'(b);
    num_words = LW'(n);
    start = 1'b1;
    if (accepted)
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), mem_word(b + i)});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int limit);
    int k;
    k = 0;
    while (done_cnt + err_cnt == 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt + err_cnt == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: no done/err within %0d cycles", nm, limit);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_csb"}, sram_csb, 1);
    chk({nm, "_raddr"}, sram_raddr, 0);
    chk({nm, "_valid"}, w_valid, 0);
    chk({nm, "_data_zero"}, (w_data == '0), 1);
    chk({nm, "_last"}, w_last, 0);
  endtask

  // Consumer ready pattern, driven after the stimulus of the same cycle.
  initial forever begin
    int rel;
    @(posedge clk); #2;
    rel = cyc - start_cyc;
    case (ready_mode)
      1:       w_ready = (rel % 3 == 0);
      2:       w_ready = (rel >= 20);
      default: w_ready = 1'b1;
    endcase
  end

  // Monitor: stats plus scoreboard compare on every handshake.
  initial forever begin
    int rel, outst;
    logic [DW:0] e;
    @(negedge clk);
    rel = cyc - start_cyc;
    if (sram_csb == 1'b0) begin
      if (csb_cnt == 0) first_csb_rel = rel;
      csb_cnt++;
      last_raddr = sram_raddr;
    end
    if (rel == 15) csb_at15 = csb_cnt;
    outst = csb_cnt - hs_cnt;
    if (outst > max_out) max_out = outst;
    if (busy === 1'b1) busy_cnt++;
    if (w_valid === 1'b1) begin
      valid_cnt++;
      if (first_valid_rel < 0) first_valid_rel = rel;
    end
    if (done === 1'b1) begin done_cnt++; done_rel = rel; end
    if (err === 1'b1) begin err_cnt++; err_rel = rel; end
    if (w_valid === 1'b1 && w_ready === 1'b1) begin
      hs_cnt++;
      last_hs_rel = rel;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word: unexpected word last=%b data=%h, expected none", w_last, w_data);
      end else begin
        e = exp_q.pop_front();
        if ({w_last, w_data} !== e)
          begin
            n_fail++;
            $display("FAIL word: got last=%b data=%h, expected last=%b data=%h",
                     w_last, w_data, e[DW], e[DW-1:0]);
          end
        else $display("ok   word rel=%0d last=%b", rel, w_last);
      end
    end
  end

  initial begin
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Long stream at full rate.
    ready_mode = 0;
    begin_cmd(21, 1000, 1);
    wait_end("t1", 1200);
    chk("t1_first_csb", first_csb_rel, 1);
    chk("t1_reads", csb_cnt, 1000);
    chk("t1_last_raddr", last_raddr, 1020);
    chk("t1_first_valid", first_valid_rel, 3);
    chk("t1_last_hs", last_hs_rel, 1002);
    chk("t1_done_rel", done_rel, 1003);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_cycles", busy_cnt, 1002);
    chk("t1_max_outstanding", max_out, 3);
    chk("t1_drained", exp_q.size(), 0);

    // Bursty consumer 1,0,0 repeating.
    ready_mode = 1;
    begin_cmd(1100, 8, 1);
    wait_end("t2", 200);
    chk("t2_words", hs_cnt, 8);
    chk("t2_reads", csb_cnt, 8);
    chk("t2_max_outstanding", max_out, FD);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_drained", exp_q.size(), 0);

    // Zero length, overflow, exact fit.
    ready_mode = 0;
    begin_cmd(5, 0, 0);
    wait_end("t3a", 20);
    chk("t3a_done_rel", done_rel, 1);
    chk("t3a_busy_cycles", busy_cnt, 0);
    chk("t3a_reads", csb_cnt, 0);
    chk("t3a_err_cnt", err_cnt, 0);
    begin_cmd(19990, 12, 0);
    wait_end("t3b", 20);
    chk("t3b_err_rel", err_rel, 1);
    chk("t3b_err_cnt", err_cnt, 1);
    chk("t3b_done_cnt", done_cnt, 0);
    chk("t3b_reads", csb_cnt, 0);
    chk("t3b_busy_cycles", busy_cnt, 0);
    begin_cmd(19990, 11, 1);
    wait_end("t3c", 100);
    chk("t3c_reads", csb_cnt, 11);
    chk("t3c_last_raddr", last_raddr, 20000);
    chk("t3c_drained", exp_q.size(), 0);

    // start held high through a 5-word command.
    @(posedge clk); #1;
    clear_stats();
    start_cyc = cyc;
    base_addr = AW'(17100);
    num_words = LW'(5);
    start = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), mem_word(17100 + i)});
    for (int k = 0; k < 100 && start; k++) begin
      @(posedge clk); #1;
      if (done) start = 1'b0;
    end
    if (start) begin
      start = 1'b0;
      n_cmp++; n_fail++;
      $display("FAIL t4_timeout: no done within 100 cycles");
    end
    repeat (3) @(negedge clk);
    chk("t4_reads", csb_cnt, 5);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_words", hs_cnt, 5);
    chk("t4_drained", exp_q.size(), 0);
    begin_cmd(17200, 2, 1);
    wait_end("t4b", 50);
    chk("t4b_done_cnt", done_cnt, 1);
    chk("t4b_drained", exp_q.size(), 0);

    // Reset the cycle after the third read of a 10-word command.
    begin_cmd(300, 10, 1);
    for (int k = 0; k < 20 && csb_cnt < 3; k++) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_reset_outputs("t5_after_rst");
    valid_cnt = 0;
    repeat (5) @(negedge clk);
    chk("t5_no_valid", valid_cnt, 0);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_no_err", err_cnt, 0);
    begin_cmd(0, 2, 1);
    wait_end("t5b", 50);
    chk("t5b_words", hs_cnt, 2);
    chk("t5b_drained", exp_q.size(), 0);

    // Consumer stalled for 20 cycles.
    ready_mode = 2;
    begin_cmd(2000, 6, 1);
    wait_end("t6", 100);
    chk("t6_reads_before_release", csb_at15, 4);
    chk("t6_last_hs", last_hs_rel, 25);
    chk("t6_done_rel", done_rel, 26);
    chk("t6_max_outstanding", max_out, FD);
    chk("t6_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
